// File: rtl/minterm_scan_if.sv
// Minterm stream: valid/ready handshake carrying one minterm index per transfer.
interface minterm_scan_if;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_index;
  logic       m_last;

  modport master (
    output m_valid,
    output m_index,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_index,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/minterm_scan.sv
// Truth-table scanner: walks abcd through 0..15, samples y after SETTLE
// cycles per code, then streams the set minterm indices in ascending order.
module minterm_scan #(
  parameter int unsigned SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  y_i,
  output logic [3:0]            abcd_o,
  output logic                  busy_o,
  output logic [15:0]           mask_o,
  output logic [4:0]            count_o,
  output logic                  done_o,
  minterm_scan_if.master        m
);

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, FIN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  abcd_q, abcd_d;
  logic [3:0]  settle_q, settle_d;
  logic [15:0] mask_q, mask_d;
  logic [15:0] rem_q, rem_d;
  logic [4:0]  count_q, count_d;
  logic [3:0]  low_idx;
  logic        last_bit;

  // Lowest set bit of the remaining-minterm set (0 when the set is empty).
  always_comb begin
    low_idx = 4'd0;
    for (int b = 15; b >= 0; b--) begin
      if (rem_q[b]) low_idx = 4'(b);
    end
  end

  // Exactly one remaining bit: clearing the lowest set bit leaves nothing.
  assign last_bit = (rem_q != 16'd0) && ((rem_q & (rem_q - 16'd1)) == 16'd0);

  // Next-state and datapath updates for the scan/emit sequence.
  always_comb begin
    state_d  = state_q;
    abcd_d   = abcd_q;
    settle_d = settle_q;
    mask_d   = mask_q;
    rem_d    = rem_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = SCAN;
          abcd_d   = 4'd0;
          settle_d = RELOAD;
          mask_d   = 16'd0;
          count_d  = 5'd0;
        end
      end
      SCAN: begin
        if (settle_q == 4'd0) begin
          mask_d[abcd_q] = y_i;
          if (y_i) count_d = count_q + 5'd1;
          abcd_d   = abcd_q + 4'd1;
          settle_d = RELOAD;
          if (abcd_q == 4'd15) begin
            // The final mask seeds the emit set; an empty table skips EMIT.
            rem_d   = mask_d;
            state_d = (mask_d == 16'd0) ? FIN : EMIT;
          end
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      EMIT: begin
        if (m.m_ready) begin
          rem_d = rem_q & (rem_q - 16'd1);
          if (last_bit) state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous reset to an idle, empty scanner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      abcd_q   <= 4'd0;
      settle_q <= 4'd0;
      mask_q   <= 16'd0;
      rem_q    <= 16'd0;
      count_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      abcd_q   <= abcd_d;
      settle_q <= settle_d;
      mask_q   <= mask_d;
      rem_q    <= rem_d;
      count_q  <= count_d;
    end
  end

  assign abcd_o    = abcd_q;
  assign mask_o    = mask_q;
  assign count_o   = count_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == FIN);
  assign m.m_valid = (state_q == EMIT);
  assign m.m_index = low_idx;
  assign m.m_last  = last_bit;

endmodule

// File: tb/tb_minterm_scan.sv
// Bench for minterm_scan: two instances (SETTLE=1 and SETTLE=3) looped back
// through a shared truth table f, checked every cycle against a timeline model.
module tb_minterm_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        m_ready = 1'b0;
  logic [15:0] f = 16'h0000;
  int          ready_mode = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  minterm_scan_if if0 ();
  minterm_scan_if if1 ();
  assign if0.m_ready = m_ready;
  assign if1.m_ready = m_ready;

  logic [3:0]  abcd0, abcd1;
  logic        busy0, busy1, done0, done1;
  logic [15:0] mask0, mask1;
  logic [4:0]  count0, count1;
  logic        y0, y1;

  assign y0 = f[abcd0];
  assign y1 = f[abcd1];

  minterm_scan #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .y_i(y0), .abcd_o(abcd0),
    .busy_o(busy0), .mask_o(mask0), .count_o(count0), .done_o(done0), .m(if0)
  );

  minterm_scan #(.SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .y_i(y1), .abcd_o(abcd1),
    .busy_o(busy1), .mask_o(mask1), .count_o(count1), .done_o(done1), .m(if1)
  );

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 scanning, 2 emitting, 3 finishing
  int          ph[2];
  int          k[2];
  logic [15:0] fm[2];
  int          ml[2][16];
  int          len[2];
  int          hd[2];

  function automatic int settle_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic model_step(int i);
    int s;
    s = settle_of(i);
    if (!rst_n) begin
      ph[i] = 0; k[i] = 0; fm[i] = 16'h0; len[i] = 0; hd[i] = 0;
    end else begin
      case (ph[i])
        0: if (start) begin ph[i] = 1; k[i] = 0; fm[i] = 16'h0; end
        1: begin
          k[i]++;
          fm[i] = f & 16'((32'h1 << (k[i] / s)) - 32'h1);
          if (k[i] == 16 * s) begin
            len[i] = 0; hd[i] = 0;
            for (int b = 0; b < 16; b++) if (f[b]) begin ml[i][len[i]] = b; len[i]++; end
            ph[i] = (len[i] == 0) ? 3 : 2;
          end
        end
        2: if (m_ready) begin hd[i]++; if (hd[i] == len[i]) ph[i] = 3; end
        default: ph[i] = 0;
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin ph[i] = 0; k[i] = 0; fm[i] = 0; len[i] = 0; hd[i] = 0; end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // ---------------- checking ----------------
  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, i, $time, act, exp);
    end
  endtask

  task automatic check_dut(int i, logic [3:0] a, logic b, logic [15:0] mk, logic [4:0] c,
                           logic d, logic v, logic [3:0] ix, logic l);
    chk("busy", i, b, ph[i] != 0);
    chk("done", i, d, ph[i] == 3);
    chk("m_valid", i, v, ph[i] == 2);
    chk("abcd", i, a, (ph[i] == 1) ? k[i] / settle_of(i) : 0);
    chk("mask", i, mk, fm[i]);
    chk("count", i, c, $countones(fm[i]));
    if (ph[i] == 2) begin
      chk("m_index", i, ix, ml[i][hd[i]]);
      chk("m_last", i, l, (len[i] - hd[i]) == 1);
    end
  endtask

  // Transfer / pulse monitors
  int em0[$], em1[$];
  bit lst0[$], lst1[$];
  int dn0 = 0, dn1 = 0, vs0 = 0;

  always @(negedge clk) begin
    check_dut(0, abcd0, busy0, mask0, count0, done0, if0.m_valid, if0.m_index, if0.m_last);
    check_dut(1, abcd1, busy1, mask1, count1, done1, if1.m_valid, if1.m_index, if1.m_last);
    if (if0.m_valid && m_ready) begin em0.push_back(int'(if0.m_index)); lst0.push_back(if0.m_last); end
    if (if1.m_valid && m_ready) begin em1.push_back(int'(if1.m_index)); lst1.push_back(if1.m_last); end
    if (done0) dn0++;
    if (done1) dn1++;
    if (if0.m_valid) vs0++;
  end

  // Consumer ready pattern
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    em0.delete(); em1.delete(); lst0.delete(); lst1.delete();
    dn0 = 0; dn1 = 0; vs0 = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while ((busy0 || busy1) && n < budget) begin tick(); n++; end
    chk("idle_timeout", 0, n < budget, 1);
  endtask

  task automatic chk_list0(int exp[], int last_at);
    chk("em_len", 0, em0.size(), exp.size());
    for (int j = 0; j < exp.size() && j < em0.size(); j++) begin
      chk("em_idx", 0, em0[j], exp[j]);
      chk("em_last", 0, lst0[j], j == last_at);
    end
  endtask

  // ---------------- test sequence ----------------
  int exp_f1[] = '{4, 5, 6, 7, 11, 12, 13};
  int exp_all[];
  int n;

  initial begin
    exp_all = new[16];
    for (int j = 0; j < 16; j++) exp_all[j] = j;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 0, busy0, 0);
    chk("rst_mask", 0, mask0, 0);
    #2 rst_n = 1'b1;
    tick();

    // Loopback f = m(4,5,6,7,11,12,13), always ready
    f = 16'h38F0; ready_mode = 0; tick();
    clear_mon();
    pulse_start();
    wait_idle(300);
    chk("s1_mask", 0, mask0, 16'h38F0);
    chk("s1_count", 0, count0, 7);
    chk("s1_done", 0, dn0, 1);
    chk_list0(exp_f1, 6);
    $display("txn scan f=38f0 ready=1 emitted=%0d done=%0d", em0.size(), dn0);

    // Same function, ready toggling every cycle
    ready_mode = 1; clear_mon();
    pulse_start();
    wait_idle(300);
    chk_list0(exp_f1, 6);
    $display("txn scan f=38f0 ready=toggle emitted=%0d", em0.size());

    // y tied 0: no minterms, done 16 cycles after scan start
    f = 16'h0000; ready_mode = 0; clear_mon();
    pulse_start();
    n = 0;
    while (!done0 && n < 40) begin tick(); n++; end
    chk("done_lat", 0, n, 16);
    wait_idle(300);
    chk("z_mask", 0, mask0, 0);
    chk("z_count", 0, count0, 0);
    chk("z_valid_seen", 0, vs0, 0);
    $display("txn scan f=0000 done_after=%0d", n);

    // y tied 1 with random ready; SETTLE=3 instance scans for 48 cycles
    f = 16'hFFFF; ready_mode = 2; clear_mon();
    pulse_start();
    n = 0;
    while (!if1.m_valid && n < 100) begin tick(); n++; end
    chk("scan_len3", 1, n, 48);
    wait_idle(600);
    chk("ones_count3", 1, count1, 16);
    chk("ones_len3", 1, em1.size(), 16);
    for (int j = 0; j < em1.size(); j++) chk("ones_idx3", 1, em1[j], j);
    chk_list0(exp_all, 15);
    $display("txn scan f=ffff emitted0=%0d emitted1=%0d", em0.size(), em1.size());

    // Randomized truth tables, ready, and start pulses (also during busy)
    for (int it = 0; it < 6; it++) begin
      f = 16'($urandom); ready_mode = 2; clear_mon();
      for (int c = 0; c < 150; c++) begin
        start = ($urandom_range(0, 3) == 0);
        tick();
      end
      start = 1'b0;
      wait_idle(600);
      $display("txn random f=%04h scans0=%0d scans1=%0d", f, dn0, dn1);
    end

    // Reset in the middle of EMIT after two transfers
    f = 16'h38F0; ready_mode = 0; tick(); clear_mon();
    pulse_start();
    n = 0;
    while (em0.size() < 2 && n < 100) begin @(negedge clk); #1; n++; end
    chk("pre_rst_xfers", 0, em0.size(), 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 0, busy0, 0);
    chk("rst_valid", 0, if0.m_valid, 0);
    chk("rst_index", 0, if0.m_index, 0);
    chk("rst_last", 0, if0.m_last, 0);
    chk("rst_mask", 0, mask0, 0);
    chk("rst_count", 0, count0, 0);
    chk("rst_abcd", 1, abcd1, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    clear_mon();
    repeat (5) tick();
    chk("post_rst_quiet", 0, dn0 + vs0, 0);
    pulse_start();
    wait_idle(300);
    chk_list0(exp_f1, 6);
    chk("rerun_mask", 0, mask0, 16'h38F0);
    $display("txn reset-mid-emit rerun emitted=%0d", em0.size());

    // start held high across several scans
    f = 16'h0081; ready_mode = 0; clear_mon();
    start = 1'b1;
    repeat (80) tick();
    start = 1'b0;
    wait_idle(300);
    chk("held_scans", 0, dn0 >= 3, 1);
    chk("held_even", 0, em0.size(), 2 * dn0);
    for (int j = 0; j < em0.size(); j++) chk("held_idx", 0, em0[j], (j % 2 == 0) ? 0 : 7);
    $display("txn start-held scans0=%0d scans1=%0d", dn0, dn1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
